// File: rtl/filter_noc_pkg.sv
// Shared types and width helpers for the filter network-on-chip blocks.
package filter_noc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scatter_state_t;

    // R*r*t fits in the sum of the operand widths, so the pass size never overflows.
    function automatic int count_width(input int rows_w, input int rep_w, input int sets_w);
        return rows_w + rep_w + sets_w;
    endfunction

endpackage

// File: rtl/filter_bus_stage.sv
// Single-entry valid/ready holding register for one filter bus word and its tags.
module filter_bus_stage #(
    parameter int DATA_WIDTH    = 64,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic [ROW_TAG_WIDTH-1:0] load_row_tag,
    input  logic [COL_TAG_WIDTH-1:0] load_col_tag,
    input  logic                     bus_ready,
    output logic [DATA_WIDTH-1:0]    bus_data,
    output logic [ROW_TAG_WIDTH-1:0] bus_row_tag,
    output logic [COL_TAG_WIDTH-1:0] bus_col_tag,
    output logic                     bus_valid,
    output logic                     free
);

    logic load_en;

    assign free    = !bus_valid || bus_ready;
    assign load_en = load && free;

    // A capture in the same cycle as a handshake replaces the outgoing word without a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_data    <= '0;
            bus_row_tag <= '0;
            bus_col_tag <= '0;
            bus_valid   <= 1'b0;
        end else if (load_en) begin
            bus_data    <= load_data;
            bus_row_tag <= load_row_tag;
            bus_col_tag <= load_col_tag;
            bus_valid   <= 1'b1;
        end else if (bus_ready) begin
            bus_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/filter_scatter_driver.sv
// Pops filter words from the global buffer FIFO and scatters them onto the PE filter bus with tags.
module filter_scatter_driver
    import filter_noc_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int R_WIDTH       = 4,
    parameter int r_WIDTH       = 2,
    parameter int t_WIDTH       = 3,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [R_WIDTH-1:0]       R,
    input  logic [r_WIDTH-1:0]       r,
    input  logic [t_WIDTH-1:0]       t,
    output logic                     tag_start,
    output logic                     tag_enable,
    input  logic [ROW_TAG_WIDTH-1:0] row_tag,
    input  logic [COL_TAG_WIDTH-1:0] col_tag,
    input  logic [DATA_WIDTH-1:0]    glb_data,
    input  logic                     glb_valid,
    output logic                     glb_ready,
    output logic [DATA_WIDTH-1:0]    bus_data,
    output logic [ROW_TAG_WIDTH-1:0] bus_row_tag,
    output logic [COL_TAG_WIDTH-1:0] bus_col_tag,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int COUNT_WIDTH = count_width(R_WIDTH, r_WIDTH, t_WIDTH);

    scatter_state_t           state, next_state;
    logic [COUNT_WIDTH-1:0]   total;
    logic [COUNT_WIDTH-1:0]   issue_cnt;
    logic [COUNT_WIDTH-1:0]   start_total;
    logic                     accept;
    logic                     last_word;
    logic                     stage_free;

    assign start_total = COUNT_WIDTH'(R) * COUNT_WIDTH'(r) * COUNT_WIDTH'(t);
    assign last_word   = (issue_cnt == total - COUNT_WIDTH'(1));
    assign glb_ready   = accept;
    assign tag_enable  = accept;

    // Next-state decode; a zero-sized pass skips the generator entirely.
    always_comb begin
        next_state = state;
        tag_start  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_total == '0) begin
                        next_state = DONE;
                    end else begin
                        tag_start  = 1'b1;
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                accept = glb_valid && stage_free;
                if (accept && last_word) next_state = DRAIN;
            end
            DRAIN: begin
                if (stage_free) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Pass size is captured once at start so later changes to R/r/t have no effect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            total     <= '0;
            issue_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= (next_state == DONE);
            if (state == IDLE && start) begin
                total     <= start_total;
                issue_cnt <= '0;
            end else if (accept) begin
                issue_cnt <= issue_cnt + COUNT_WIDTH'(1);
            end
        end
    end

    filter_bus_stage #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ROW_TAG_WIDTH (ROW_TAG_WIDTH),
        .COL_TAG_WIDTH (COL_TAG_WIDTH)
    ) u_bus_stage (
        .clk          (clk),
        .reset        (reset),
        .load         (accept),
        .load_data    (glb_data),
        .load_row_tag (row_tag),
        .load_col_tag (col_tag),
        .bus_ready    (bus_ready),
        .bus_data     (bus_data),
        .bus_row_tag  (bus_row_tag),
        .bus_col_tag  (bus_col_tag),
        .bus_valid    (bus_valid),
        .free         (stage_free)
    );

endmodule

// File: tb/tb_filter_scatter_driver.sv
// Scoreboard bench for filter_scatter_driver with a behavioural tag generator and FIFO.
module tb_filter_scatter_driver;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  row;
        logic [3:0]  col;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cfg_R = '0;
    logic [1:0]  cfg_r = '0;
    logic [2:0]  cfg_t = '0;
    logic        tag_start, tag_enable;
    logic [3:0]  row_tag, col_tag;
    logic [63:0] glb_data;
    logic        glb_valid = 1'b0;
    logic        glb_ready;
    logic [63:0] bus_data;
    logic [3:0]  bus_row_tag, bus_col_tag;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        busy, done;

    word_t       exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          xfer_cnt = 0;
    int          te_cnt = 0;
    int          ts_cnt = 0;
    int          gr_cnt = 0;
    logic [55:0] pop_cnt = '0;
    logic [7:0]  pass_id = '0;
    int          gen_row = 0;
    int          gen_col = 0;
    int          gen_cols = 1;
    logic [71:0] held = '0;
    bit          stalled_prev = 1'b0;

    always #5 clk = ~clk;

    filter_scatter_driver dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .R           (cfg_R),
        .r           (cfg_r),
        .t           (cfg_t),
        .tag_start   (tag_start),
        .tag_enable  (tag_enable),
        .row_tag     (row_tag),
        .col_tag     (col_tag),
        .glb_data    (glb_data),
        .glb_valid   (glb_valid),
        .glb_ready   (glb_ready),
        .bus_data    (bus_data),
        .bus_row_tag (bus_row_tag),
        .bus_col_tag (bus_col_tag),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .busy        (busy),
        .done        (done)
    );

    // FIFO model: head word carries the pass id and the running pop index.
    assign glb_data = {pass_id, pop_cnt};
    always @(posedge clk) if (glb_ready) pop_cnt <= pop_cnt + 56'd1;

    // Tag generator model: columns wrap at r*t, rows advance on each wrap.
    assign row_tag = 4'(gen_row);
    assign col_tag = 4'(gen_col);
    always @(posedge clk) begin
        if (!reset) begin
            gen_row <= 0;
            gen_col <= 0;
        end else if (tag_start) begin
            gen_row  <= 0;
            gen_col  <= 0;
            gen_cols <= int'(cfg_r) * int'(cfg_t);
        end else if (tag_enable) begin
            if (gen_col == gen_cols - 1) begin
                gen_col <= 0;
                gen_row <= gen_row + 1;
            end else begin
                gen_col <= gen_col + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall behaviour.
    always @(negedge clk) begin
        if (!reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (tag_enable) te_cnt++;
            if (tag_start)  ts_cnt++;
            if (glb_ready)  gr_cnt++;
            if (bus_valid && bus_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL spurious word: got %0h, expected no word", bus_data);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    checkOutput("bus_data", 128'(bus_data), 128'(e.data));
                    checkOutput("bus_row_tag", 128'(bus_row_tag), 128'(e.row));
                    checkOutput("bus_col_tag", 128'(bus_col_tag), 128'(e.col));
                end
                stalled_prev = 1'b0;
            end else if (bus_valid) begin
                checkOutput("stall glb_ready", 128'(glb_ready), 128'(0));
                checkOutput("stall tag_enable", 128'(tag_enable), 128'(0));
                if (stalled_prev)
                    checkOutput("stall hold", 128'({bus_data, bus_row_tag, bus_col_tag}), 128'(held));
                held = {bus_data, bus_row_tag, bus_col_tag};
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input int n_rows, input int n_rep, input int n_sets, input bit gap,
                                 input int stall_at, input int busy_start_at, input int reset_after,
                                 input int exp_latency);
        int  n;
        int  cols;
        int  c;
        bit  seen_done;
        n    = n_rows * n_rep * n_sets;
        cols = (n_rep * n_sets == 0) ? 1 : n_rep * n_sets;
        pass_id = pass_id + 8'd1;
        for (int k = 0; k < n; k++)
            exp_q.push_back('{data: {pass_id, pop_cnt + 56'(k)}, row: 4'(k / cols), col: 4'(k % cols)});
        xfer_cnt = 0; te_cnt = 0; ts_cnt = 0; gr_cnt = 0;
        cfg_R = 4'(n_rows); cfg_r = 2'(n_rep); cfg_t = 3'(n_sets);
        start = 1'b1; glb_valid = 1'b1; bus_ready = 1'b1;
        c = 0; seen_done = 1'b0;
        while (c < 300 && !seen_done) begin
            @(posedge clk); #1;
            c++;
            start = (c == busy_start_at);
            cfg_R = 4'hF; cfg_r = 2'h3; cfg_t = 3'h7;
            if (gap) glb_valid = ~glb_valid;
            bus_ready = !(stall_at > 0 && c >= stall_at && c < stall_at + 3);
            if (reset_after > 0 && xfer_cnt == reset_after) begin
                reset = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                checkOutput("bus_valid after reset", 128'(bus_valid), 128'(0));
                checkOutput("busy after reset", 128'(busy), 128'(0));
                exp_q.delete();
                return;
            end
            if (done) begin
                seen_done = 1'b1;
                if (exp_latency > 0) checkOutput("done latency", 128'(c), 128'(exp_latency));
            end
        end
        if (!seen_done) begin
            tests++;
            fails++;
            $display("[TB] FAIL done timeout: got no done in %0d cycles, expected done", c);
        end
        @(posedge clk); #1;
        checkOutput("done width", 128'(done), 128'(0));
        checkOutput("busy at end", 128'(busy), 128'(0));
        checkOutput("words delivered", 128'(xfer_cnt), 128'(n));
        checkOutput("tag_enable pulses", 128'(te_cnt), 128'(n));
        checkOutput("glb_ready pops", 128'(gr_cnt), 128'(n));
        checkOutput("tag_start pulses", 128'(ts_cnt), 128'(n > 0 ? 1 : 0));
        checkOutput("scoreboard empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 128'(busy), 128'(0));
        checkOutput("reset done", 128'(done), 128'(0));
        checkOutput("reset bus_valid", 128'(bus_valid), 128'(0));
        checkOutput("reset bus word", 128'({bus_data, bus_row_tag, bus_col_tag}), 128'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic pass");
        applyStimulus(3, 2, 2, 1'b0, 0, 0, 0, 14);
        $display("[TB] backpressure");
        applyStimulus(3, 2, 2, 1'b0, 5, 0, 0, 17);
        $display("[TB] fifo gaps");
        applyStimulus(3, 2, 2, 1'b1, 0, 0, 0, 0);
        $display("[TB] zero size");
        applyStimulus(3, 2, 0, 1'b0, 0, 0, 0, 1);
        $display("[TB] reset mid-pass then restart");
        applyStimulus(3, 2, 2, 1'b0, 0, 0, 5, 0);
        applyStimulus(3, 2, 2, 1'b0, 0, 0, 0, 14);
        $display("[TB] start while busy");
        applyStimulus(3, 2, 2, 1'b0, 0, 4, 0, 14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_scatter_driver.md
# filter_scatter_driver

Drives filter weights from the global-buffer read FIFO onto the filter global-input bus of the PE array, one word per transfer, each stamped with the row/column tag of its destination PE. It sits directly downstream of the filter tag generator. It starts that generator, advances it once per accepted word, and latches the tag it currently presents together with the data word. A single-entry output stage gives full throughput under bus backpressure.

## Interface
Parameters:
- DATA_WIDTH, 64, width of one filter bus word
- R_WIDTH, 4, width of the filter-row count R
- r_WIDTH, 2, width of the per-PE-set replication count r
- t_WIDTH, 3, width of the filter-set count t
- ROW_TAG_WIDTH, 4, row tag width
- COL_TAG_WIDTH, 4, column tag width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset: sampled on clk; 0 resets the block
- start  in  1  one-cycle request to begin a filter pass; honoured only in IDLE
- R  in  R_WIDTH  filter rows per pass
- r  in  r_WIDTH  replication count per pass
- t  in  t_WIDTH  filter sets per pass
- tag_start  out  1  start pulse to the tag generator
- tag_enable  out  1  advances the tag generator by one position
- row_tag  in  ROW_TAG_WIDTH  current row tag from the generator
- col_tag  in  COL_TAG_WIDTH  current column tag from the generator
- glb_data  in  DATA_WIDTH  filter word at the head of the FIFO
- glb_valid  in  1  FIFO is not empty
- glb_ready  out  1  pop strobe for the FIFO
- bus_data  out  DATA_WIDTH  filter bus word
- bus_row_tag  out  ROW_TAG_WIDTH  destination row tag
- bus_col_tag  out  COL_TAG_WIDTH  destination column tag
- bus_valid  out  1  bus word is valid
- bus_ready  in  1  all tag-matched PEs accept the word
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when the pass is complete

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **IDLE:**
  - On start, latch total = R*r*t. The product is unsigned and COUNT_WIDTH = R_WIDTH+r_WIDTH+t_WIDTH bits wide, so it never overflows.
  - Pulse tag_start in the same cycle, clear the issue counter, and go to RUN.
  - If total == 0, go to DONE instead and do not pulse tag_start.
- **RUN:**
  - The capture condition is accept = glb_valid && (!bus_valid || bus_ready).
  - glb_ready = accept and tag_enable = accept. Both are combinational and are 0 outside RUN.
  - On accept, load the output stage with {glb_data, row_tag, col_tag}, set bus_valid, and increment the issue counter.
  - When accept occurs with issue counter == total-1, go to DRAIN.
- **Output stage:**
  - bus_valid clears on bus_ready unless a new word is captured in the same cycle.
  - While bus_valid is high and bus_ready is low, bus_data and both bus tags hold stable.
- **DRAIN:** when bus_valid is low, or bus_valid && bus_ready, go to DONE.
- **DONE:** assert done for exactly one cycle, then go to IDLE.
- **Ignored inputs:**
  - start in any state other than IDLE is ignored.
  - Changes to R, r or t after the start cycle are ignored.
- **Reset (reset low on a clk edge):**
  - The state returns to IDLE.
  - bus_valid, done, busy, the issue counter and total all go to 0.
  - bus_data and the bus tags go to 0.
  - Reset applied mid-pass discards the word held in the output stage. The generator must be reset by the same signal.

## Timing
- tag_start is asserted in the start cycle. The first accept can occur in the following cycle, once the generator is counting.
- Latency from a FIFO pop to bus_valid is 1 cycle.
- Throughput is 1 word per cycle when glb_valid and bus_ready are held high. A pass of N words then ends with done N+2 cycles after start: 1 cycle to enter RUN, N accepts, the last word draining, then DONE.
- The tags travelling with each word are the generator outputs in the accept cycle. The generator advances on that edge, so consecutive words carry consecutive tags.
- All outputs are registered except glb_ready, tag_enable and tag_start.

## Structure
- Shared package filter_noc_pkg holds:
  - the state enum scatter_state_t {IDLE, RUN, DRAIN, DONE};
  - the COUNT_WIDTH derivation.
- Sub-module filter_bus_stage: the single-entry valid/ready register for data plus tags, with the accept and hold logic.

## Test plan
- **Basic pass.** R=3, r=2, t=2, FIFO always valid, bus_ready=1 → 12 words on the bus with col_tag sequence 0,1,2,3 repeated per row and row_tag 0,0,0,0,1,…,2. done pulses 14 cycles after start.
- **Backpressure.** Same config; drop bus_ready low for 3 cycles mid-pass → bus_data and tags hold steady, no FIFO pop and no tag_enable during the stall, and no word is lost or duplicated.
- **FIFO underflow gaps.** glb_valid toggles every other cycle → 12 words delivered in order, and tag_enable pulses exactly 12 times.
- **Zero size.** t=0 with start → no tag_start and no glb_ready; done pulses 1 cycle after start.
- **Reset and restart.** Pull reset low for 1 cycle after 5 words → bus_valid=0 and busy=0 the next cycle. A new start then runs a complete 12-word pass from tag (0,0).
- **Start while busy.** Pulse start during RUN → ignored, and the pass count remains 12.
